// File: rtl/snn_pkg.sv
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared SNN types and constants (LIF state encoding,
//                default membrane width, saturation bounds).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_pkg;

  typedef enum logic [2:0] {
    LIF_ACCUM   = 3'd0,
    LIF_LEAK    = 3'd1,
    LIF_EVAL    = 3'd2,
    LIF_FIRE    = 3'd3,
    LIF_REFRACT = 3'd4
  } lif_state_t;

  localparam int DEFAULT_MEM_WIDTH = 16;

  localparam logic signed [DEFAULT_MEM_WIDTH-1:0] SAT_MAX_DEFAULT =
    {1'b0, {(DEFAULT_MEM_WIDTH-1){1'b1}}};
  localparam logic signed [DEFAULT_MEM_WIDTH-1:0] SAT_MIN_DEFAULT =
    {1'b1, {(DEFAULT_MEM_WIDTH-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/lif_neuron_accum_if.sv
// ============================================================================
//  Module      : lif_neuron_accum_if
//  Description : Weight stream, fetch strobe, spike handshake and status bus
//                of the LIF neuron stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lif_neuron_accum_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 14
);

  logic                  i_weight_valid;
  logic [DATA_WIDTH-1:0] i_weight_data;
  logic                  i_fetch_done;
  logic                  o_spike_valid;
  logic                  i_spike_ready;
  logic [ADDR_WIDTH-1:0] o_spike_addr;
  logic [MEM_WIDTH-1:0]  o_membrane;
  logic                  o_update_done;
  logic                  o_drop;
  logic                  o_busy;

  modport master (
    output i_weight_valid, i_weight_data, i_fetch_done, i_spike_ready,
    input  o_spike_valid, o_spike_addr, o_membrane, o_update_done, o_drop, o_busy
  );

  modport slave (
    input  i_weight_valid, i_weight_data, i_fetch_done, i_spike_ready,
    output o_spike_valid, o_spike_addr, o_membrane, o_update_done, o_drop, o_busy
  );

endinterface

`default_nettype wire

// File: rtl/sat_add.sv
// ============================================================================
//  Module      : sat_add
//  Description : Signed combinational adder clamped to the representable range.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_add #(
  parameter int WIDTH = 16
) (
  input  wire logic signed [WIDTH-1:0] a,
  input  wire logic signed [WIDTH-1:0] b,
  output logic signed      [WIDTH-1:0] sum_sat
);

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] w_sum;

  assign w_sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  // Overflow shows up as disagreement between the guard bit and the MSB.
  always_comb begin
    sum_sat = w_sum[WIDTH-1:0];
    if (w_sum[WIDTH] != w_sum[WIDTH-1]) begin
      sum_sat = w_sum[WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lif_neuron_accum.sv
// ============================================================================
//  Module      : lif_neuron_accum
//  Description : Leaky integrate-and-fire neuron: saturating accumulate, leak,
//                threshold, spike handshake and refractory hold.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_neuron_accum
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_WIDTH      = DEFAULT_MEM_WIDTH,
  parameter int ADDR_WIDTH     = 14,
  parameter int NEURON_ID      = 0,
  parameter int THRESHOLD      = 100,
  parameter int V_RESET        = 0,
  parameter int LEAK_SHIFT     = 3,
  parameter int REFRACT_CYCLES = 4
) (
  input wire logic          clk,
  input wire logic          rst_n,
  lif_neuron_accum_if.slave nif
);

  localparam int CNT_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam bit REFRACT_EN = (REFRACT_CYCLES > 0);

  localparam logic signed [MEM_WIDTH-1:0] THR_VAL   = MEM_WIDTH'(THRESHOLD);
  localparam logic signed [MEM_WIDTH-1:0] V_RST_VAL = MEM_WIDTH'(V_RESET);
  localparam logic [ADDR_WIDTH-1:0]       SPIKE_ID  = ADDR_WIDTH'(NEURON_ID);
  localparam logic [CNT_W-1:0]            CNT_LOAD  = CNT_W'(REFRACT_CYCLES);

  lif_state_t                   r_state, w_state_next;
  logic signed [MEM_WIDTH-1:0]  r_membrane, w_mem_next;
  logic [CNT_W-1:0]             r_cnt, w_cnt_next;

  logic signed [MEM_WIDTH-1:0]  w_weight_ext;
  logic signed [MEM_WIDTH-1:0]  w_acc_sum;
  logic                         w_spike_valid;
  logic                         w_update_done;

  assign w_weight_ext = {{(MEM_WIDTH-DATA_WIDTH){nif.i_weight_data[DATA_WIDTH-1]}},
                         nif.i_weight_data};

  sat_add #(
    .WIDTH (MEM_WIDTH)
  ) u_sat_add (
    .a       (r_membrane),
    .b       (w_weight_ext),
    .sum_sat (w_acc_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LIF_ACCUM;
      r_membrane <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_membrane <= w_mem_next;
      r_cnt      <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_mem_next    = r_membrane;
    w_cnt_next    = r_cnt;
    w_spike_valid = 1'b0;
    w_update_done = 1'b0;

    case (r_state)
      LIF_ACCUM: begin
        // A beat coinciding with fetch_done is integrated before the leak.
        if (nif.i_weight_valid) begin
          w_mem_next = w_acc_sum;
        end
        if (nif.i_fetch_done) begin
          w_state_next = LIF_LEAK;
        end
      end
      LIF_LEAK: begin
        w_mem_next   = r_membrane - (r_membrane >>> LEAK_SHIFT);
        w_state_next = LIF_EVAL;
      end
      LIF_EVAL: begin
        if (r_membrane >= THR_VAL) begin
          w_state_next = LIF_FIRE;
        end else begin
          w_update_done = 1'b1;
          w_state_next  = LIF_ACCUM;
        end
      end
      LIF_FIRE: begin
        w_spike_valid = 1'b1;
        if (nif.i_spike_ready) begin
          w_mem_next = V_RST_VAL;
          if (REFRACT_EN) begin
            w_cnt_next   = CNT_LOAD;
            w_state_next = LIF_REFRACT;
          end else begin
            w_update_done = 1'b1;
            w_state_next  = LIF_ACCUM;
          end
        end
      end
      LIF_REFRACT: begin
        w_mem_next = V_RST_VAL;
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_next    = '0;
          w_update_done = 1'b1;
          w_state_next  = LIF_ACCUM;
        end
      end
      default: begin
        w_state_next = LIF_ACCUM;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs decode the asynchronously-reset state, so they clear with rst_n.
  assign nif.o_spike_valid = w_spike_valid;
  assign nif.o_spike_addr  = w_spike_valid ? SPIKE_ID : '0;
  assign nif.o_membrane    = r_membrane;
  assign nif.o_update_done = w_update_done;
  assign nif.o_drop        = nif.i_weight_valid && (r_state != LIF_ACCUM);
  assign nif.o_busy        = (r_state != LIF_ACCUM);

endmodule

`default_nettype wire

// File: doc/lif_neuron_accum.md
# lif_neuron_accum

Leaky integrate-and-fire neuron stage directly downstream of `synapse_mem_ctrl`. It consumes the weight stream (`o_weight_valid` / `o_weight_data`) and the end-of-fetch strobe (`o_fetch_done`). It accumulates signed weights into a saturating membrane potential. At end of fetch it applies leak, compares against threshold, emits an output spike address over a valid/ready handshake, and then enforces a refractory period.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: weight width, two's-complement signed.
- `MEM_WIDTH`, 16: membrane potential width, signed.
- `ADDR_WIDTH`, 14: output spike address width.
- `NEURON_ID`, 0: address emitted on fire.
- `THRESHOLD`, 100: fire when membrane ≥ THRESHOLD (signed compare).
- `V_RESET`, 0: membrane value after fire.
- `LEAK_SHIFT`, 3: leak amount = membrane >>> LEAK_SHIFT.
- `REFRACT_CYCLES`, 4: refractory length in cycles; 0 disables the refractory period.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `i_weight_valid`, in, 1: weight beat valid.
- `i_weight_data`, in, DATA_WIDTH: signed weight.
- `i_fetch_done`, in, 1: one-cycle pulse marking the end of the timestep's weights.
- `o_spike_valid`, out, 1: output spike pending.
- `i_spike_ready`, in, 1: downstream accepts the spike.
- `o_spike_addr`, out, ADDR_WIDTH: equals NEURON_ID while `o_spike_valid` is high; otherwise 0.
- `o_membrane`, out, MEM_WIDTH: current membrane register.
- `o_update_done`, out, 1: one-cycle pulse when the timestep completes.
- `o_drop`, out, 1: one-cycle pulse when a weight beat is discarded.
- `o_busy`, out, 1: high in any state other than ACCUM.

## Operation

- **States:** ACCUM (idle/integrate), LEAK, EVAL, FIRE, REFRACT.
- **ACCUM**
  - On `i_weight_valid`: membrane ← sat(membrane + sign_extend(weight)).
  - On `i_fetch_done`: go to LEAK.
  - Simultaneous valid and fetch_done: accumulate the weight first, then go to LEAK.
- **LEAK:** membrane ← membrane − (membrane >>> LEAK_SHIFT), arithmetic shift; cannot overflow. Go to EVAL.
- **EVAL**
  - If membrane ≥ THRESHOLD: go to FIRE.
  - Else: pulse `o_update_done` and go to ACCUM.
- **FIRE**
  - `o_spike_valid`=1 and `o_spike_addr`=NEURON_ID, held stable until `i_spike_ready`.
  - On handshake: membrane ← V_RESET.
    - REFRACT_CYCLES=0: pulse `o_update_done` and go to ACCUM.
    - Otherwise: load the refractory counter with REFRACT_CYCLES and go to REFRACT.
- **REFRACT**
  - Counter decrements each cycle; membrane is held at V_RESET.
  - When the counter reaches 1 (i.e. on the last cycle), pulse `o_update_done` and go to ACCUM.
- **Saturation:** clamp to [−2^(MEM_WIDTH−1), 2^(MEM_WIDTH−1)−1]. No wrap-around, ever.
- **Dropped beats:** any `i_weight_valid` outside ACCUM is discarded and pulses `o_drop` in the same cycle. `i_fetch_done` outside ACCUM is ignored.
- **Reset** (any time, including mid-FIRE): state=ACCUM, membrane=0, counter=0. All outputs go to 0 asynchronously.

## Timing

- Weight sampled at edge t → `o_membrane` reflects it after edge t (one-cycle latency, back-to-back beats every cycle).
- Fetch_done sampled at edge t:
  - LEAK during cycle t+1.
  - EVAL during cycle t+2.
  - `o_spike_valid` rises after edge t+2 (earliest visible cycle t+3), or `o_update_done` is high in cycle t+2 if there is no fire.
- Spike handshake completes on the edge where `o_spike_valid` and `i_spike_ready` are both 1. `o_spike_valid` drops the next cycle.
- REFRACT occupies exactly REFRACT_CYCLES cycles after the handshake. `o_update_done` is high in the last one.
- `o_update_done` is asserted exactly once per fetch_done accepted in ACCUM.

## Structure

- **Shared package `snn_pkg`** (include header for Verilog-2001):
  - state encodings (LIF_ACCUM, LIF_LEAK, LIF_EVAL, LIF_FIRE, LIF_REFRACT);
  - default MEM_WIDTH;
  - saturation min/max helper constants.
- **Sub-module `sat_add`** (parameterised width, signed, combinational clamp). It is reused later by multi-neuron arrays.
- FSM, membrane register and refractory counter live in the top.

## Test plan

All cases use defaults; weights are hex.

- **Fire path:** weights 0x28, 0x28, 0x28 (120), then fetch_done → leak gives 105, spike_valid with addr=NEURON_ID, membrane=0 after handshake, update_done 4 cycles after handshake.
- **No fire:** weights 0x28, 0x28 (80), then fetch_done → membrane 70, no spike, update_done in the EVAL cycle, o_busy low next cycle.
- **Saturation:** 300 beats of 0x7F → membrane 32767 (no wrap). 300 beats of 0x80 from reset → −32768. Leak of −8 → −7.
- **Backpressure:** i_spike_ready held low for 10 cycles in FIRE → spike_valid/addr stable for all 10. A weight 0x10 arriving during FIRE pulses o_drop and leaves membrane unchanged. Release ready → REFRACT.
- **Simultaneous:** weight 0x64 and fetch_done in the same cycle from membrane 0 → accumulated to 100, leaked to 88, no fire.
- **Reset mid-operation:** assert rst_n low during REFRACT and during FIRE → all outputs 0 immediately (asynchronous). After release, state=ACCUM and membrane=0.
